// File: rtl/controller.sv
// Sequencing FSM for the Sobel edge-detection datapath. Fetches a full 3x3 window
// (nine read/latch pairs), runs the gradient stages, writes the result and advances
// the window. Each later window needs three new pixels only. Every output is a level
// start strobe decoded from the current state alone.
module controller (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic load_done,
  input  logic read_data_done,
  input  logic read_done,
  input  logic h_done,
  input  logic v_done,
  input  logic calculation_done,
  input  logic write_done,
  input  logic move_done,
  input  logic all_done,
  input  logic shift_done,
  output logic load_initial,
  output logic start_9_read,
  output logic start_read,
  output logic start_calculation,
  output logic start_t_grad,
  output logic start_write,
  output logic start_move,
  output logic start_shift,
  output logic start_i_read
);

  typedef enum logic [4:0] {
    StIdle,
    StLoadParam,
    StRPixel1, StRPixel2, StRPixel3, StRPixel4, StRPixel5,
    StRPixel6, StRPixel7, StRPixel8, StRPixel9,
    StLPixel1, StLPixel2, StLPixel3, StLPixel4, StLPixel5,
    StLPixel6, StLPixel7, StLPixel8, StLPixel9,
    StGradient,
    StTGradient,
    StWrite,
    StCheckPixel,
    StShiftP1,
    StReadP1, StReadP2, StReadP3,
    StLoadP1, StLoadP2, StLoadP3,
    StImageDone
  } state_e;

  state_e state_q, state_d;

  // State register; reset forces IDLE at once, independent of the clock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each state waits on its own handshake and ignores everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (start)          state_d = StLoadParam;
      StLoadParam: if (load_done)      state_d = StRPixel1;
      // Initial window: memory read then latch, nine times.
      StRPixel1:   if (read_data_done) state_d = StLPixel1;
      StRPixel2:   if (read_data_done) state_d = StLPixel2;
      StRPixel3:   if (read_data_done) state_d = StLPixel3;
      StRPixel4:   if (read_data_done) state_d = StLPixel4;
      StRPixel5:   if (read_data_done) state_d = StLPixel5;
      StRPixel6:   if (read_data_done) state_d = StLPixel6;
      StRPixel7:   if (read_data_done) state_d = StLPixel7;
      StRPixel8:   if (read_data_done) state_d = StLPixel8;
      StRPixel9:   if (read_data_done) state_d = StLPixel9;
      StLPixel1:   if (read_done)      state_d = StRPixel2;
      StLPixel2:   if (read_done)      state_d = StRPixel3;
      StLPixel3:   if (read_done)      state_d = StRPixel4;
      StLPixel4:   if (read_done)      state_d = StRPixel5;
      StLPixel5:   if (read_done)      state_d = StRPixel6;
      StLPixel6:   if (read_done)      state_d = StRPixel7;
      StLPixel7:   if (read_done)      state_d = StRPixel8;
      StLPixel8:   if (read_done)      state_d = StRPixel9;
      StLPixel9:   if (read_done)      state_d = StGradient;
      // Both gradient units must finish; one alone keeps us waiting.
      StGradient:  if (h_done && v_done) state_d = StTGradient;
      StTGradient: if (calculation_done) state_d = StWrite;
      StWrite:     if (write_done)       state_d = StCheckPixel;
      // End of image wins over a simultaneous window move.
      StCheckPixel: begin
        if (all_done) begin
          state_d = StImageDone;
        end else if (move_done) begin
          state_d = StShiftP1;
        end
      end
      StShiftP1:   if (shift_done)     state_d = StReadP1;
      // Incremental window: only the new column of three pixels.
      StReadP1:    if (read_data_done) state_d = StLoadP1;
      StReadP2:    if (read_data_done) state_d = StLoadP2;
      StReadP3:    if (read_data_done) state_d = StLoadP3;
      StLoadP1:    if (read_done)      state_d = StReadP2;
      StLoadP2:    if (read_done)      state_d = StReadP3;
      StLoadP3:    if (read_done)      state_d = StGradient;
      StImageDone: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Moore output decode: at most one strobe per state, none in IDLE/IMAGE_DONE.
  always_comb begin
    load_initial      = 1'b0;
    start_9_read      = 1'b0;
    start_read        = 1'b0;
    start_calculation = 1'b0;
    start_t_grad      = 1'b0;
    start_write       = 1'b0;
    start_move        = 1'b0;
    start_shift       = 1'b0;
    start_i_read      = 1'b0;
    case (state_q)
      StLoadParam: load_initial = 1'b1;
      StRPixel1, StRPixel2, StRPixel3, StRPixel4, StRPixel5,
      StRPixel6, StRPixel7, StRPixel8, StRPixel9: start_9_read = 1'b1;
      StLPixel1, StLPixel2, StLPixel3, StLPixel4, StLPixel5,
      StLPixel6, StLPixel7, StLPixel8, StLPixel9,
      StLoadP1, StLoadP2, StLoadP3: start_read = 1'b1;
      StGradient:   start_calculation = 1'b1;
      StTGradient:  start_t_grad      = 1'b1;
      StWrite:      start_write       = 1'b1;
      StCheckPixel: start_move        = 1'b1;
      StShiftP1:    start_shift       = 1'b1;
      StReadP1, StReadP2, StReadP3: start_i_read = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Bench for the Sobel sequencing controller: directed vector table, async-reset corner
// cases, and a randomized run against a phase/counter reference model.
module tb_controller;

  logic clk = 1'b0;
  logic n_rst;
  logic start, load_done, read_data_done, read_done, h_done, v_done;
  logic calculation_done, write_done, move_done, all_done, shift_done;
  logic load_initial, start_9_read, start_read, start_calculation, start_t_grad;
  logic start_write, start_move, start_shift, start_i_read;

  always #5 clk = ~clk;

  controller dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .load_done        (load_done),
    .read_data_done   (read_data_done),
    .read_done        (read_done),
    .h_done           (h_done),
    .v_done           (v_done),
    .calculation_done (calculation_done),
    .write_done       (write_done),
    .move_done        (move_done),
    .all_done         (all_done),
    .shift_done       (shift_done),
    .load_initial     (load_initial),
    .start_9_read     (start_9_read),
    .start_read       (start_read),
    .start_calculation(start_calculation),
    .start_t_grad     (start_t_grad),
    .start_write      (start_write),
    .start_move       (start_move),
    .start_shift      (start_shift),
    .start_i_read     (start_i_read)
  );

  // Input vector bits.
  localparam logic [10:0] IStart = 11'h400, ILoad = 11'h200, IRdd = 11'h100;
  localparam logic [10:0] IRd = 11'h080, IH = 11'h040, IV = 11'h020, ICalc = 11'h010;
  localparam logic [10:0] IWr = 11'h008, IMove = 11'h004, IAll = 11'h002;
  localparam logic [10:0] IShift = 11'h001, INone = 11'h000;
  // Output vector bits.
  localparam logic [8:0] OLi = 9'h100, O9r = 9'h080, ORd = 9'h040, OCalc = 9'h020;
  localparam logic [8:0] OTg = 9'h010, OWr = 9'h008, OMv = 9'h004, OSh = 9'h002;
  localparam logic [8:0] OIr = 9'h001, ONone = 9'h000;

  logic [8:0] out_vec;
  assign out_vec = {load_initial, start_9_read, start_read, start_calculation, start_t_grad,
                    start_write, start_move, start_shift, start_i_read};

  typedef struct {
    logic [10:0] in;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic drive(input logic [10:0] v);
    {start, load_done, read_data_done, read_done, h_done, v_done, calculation_done,
     write_done, move_done, all_done, shift_done} = v;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, then sample away from it.
  task automatic apply(input logic [10:0] v, input logic [8:0] exp, input string name);
    drive(v);
    @(posedge clk);
    #1;
    check(name, out_vec, exp);
  endtask

  function automatic void add(input logic [10:0] v, input logic [8:0] e);
    vec_t t;
    t.in = v;
    t.exp = e;
    vecs.push_back(t);
  endfunction

  task automatic do_reset();
    n_rst = 1'b0;
    drive(INone);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Reference model: abstract phase plus count of pixels latched in the current fill.
  int ph;      // 0 idle,1 param,2 mem read,3 latch,4 grad,5 tgrad,6 write,7 check,8 shift,9 done
  int got;
  bit full;

  function automatic logic [8:0] model_out();
    case (ph)
      1: return OLi;
      2: return full ? O9r : OIr;
      3: return ORd;
      4: return OCalc;
      5: return OTg;
      6: return OWr;
      7: return OMv;
      8: return OSh;
      default: return ONone;
    endcase
  endfunction

  function automatic void model_step(input logic [10:0] v);
    case (ph)
      0: if ((v & IStart) != 0) ph = 1;
      1: if ((v & ILoad) != 0) begin ph = 2; got = 0; full = 1'b1; end
      2: if ((v & IRdd) != 0) ph = 3;
      3: if ((v & IRd) != 0) begin
           got++;
           ph = (got == (full ? 9 : 3)) ? 4 : 2;
         end
      4: if ((v & IH) != 0 && (v & IV) != 0) ph = 5;
      5: if ((v & ICalc) != 0) ph = 6;
      6: if ((v & IWr) != 0) ph = 7;
      7: if ((v & IAll) != 0) ph = 9;
         else if ((v & IMove) != 0) begin ph = 8; end
      8: if ((v & IShift) != 0) begin ph = 2; got = 0; full = 1'b0; end
      default: ph = 0;
    endcase
  endfunction

  initial begin
    // Reset held with start high: must stay in IDLE.
    n_rst = 1'b0;
    drive(IStart);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", out_vec, ONone);
    n_rst = 1'b1;
    apply(INone, ONone, "reset_release_idle");

    // Directed table covering the full first window, one incremental window and completion.
    add(IAll | IShift | ILoad, ONone);    // done inputs ignored in IDLE
    add(IStart, OLi);
    add(INone, OLi);
    add(ILoad, O9r);
    for (int n = 1; n <= 9; n++) begin
      add(IRdd, ORd);
      add(IRdd, ORd);                     // held read_data_done ignored while latching
      add(IRd, (n < 9) ? O9r : OCalc);
      if (n < 9) add(IRd, O9r);           // held read_done ignored while reading
    end
    add(IH, OCalc);
    add(IV, OCalc);
    add(IH | IV, OTg);
    add(ICalc, OWr);
    add(IWr, OMv);
    add(IMove, OSh);
    add(IShift, OIr);
    for (int n = 1; n <= 3; n++) begin
      add(IRdd, ORd);
      add(IRd, (n < 3) ? OIr : OCalc);
    end
    add(IH | IV, OTg);
    add(ICalc, OWr);
    add(IWr, OMv);
    add(IAll | IMove, ONone);             // all_done wins -> IMAGE_DONE
    add(INone, ONone);                    // back to IDLE
    add(IStart, OLi);
    do_reset();
    foreach (vecs[i]) apply(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    // Abort in GRADIENT: output must clear without a clock edge.
    do_reset();
    apply(IStart, OLi, "abort_start");
    apply(ILoad, O9r, "abort_load");
    for (int n = 1; n <= 9; n++) begin
      apply(IRdd, ORd, "abort_rdd");
      apply(IRd, (n < 9) ? O9r : OCalc, "abort_rd");
    end
    drive(INone);
    #2;
    n_rst = 1'b0;
    #1;
    check("abort_async_clear", out_vec, ONone);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_after", out_vec, ONone);

    // Randomized run against the reference model.
    do_reset();
    ph = 0; got = 0; full = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic [10:0] v;
      v = 11'($urandom) & ~IAll;
      if ($urandom_range(15) == 0) v = v | IAll;
      drive(v);
      @(posedge clk);
      model_step(v);
      #1;
      check("random", out_vec, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
